altera_emif_arch_nf_hs_pipe: RTL
================================

// Module: altera_emif_arch_nf_hs_pipe
//
// PURPOSE
//  Parametrised valid/ready pipeline for C2P/P2C paths between core logic and the EMIF.
//  It is a chain of DEPTH full-throughput skid-buffer stages with registered ready at every stage.
//  Each stage holds up to 2 beats, so backpressure never creates a combinational path across the chain.
//  DEPTH=0 gives a pure wire-through.
//  Placed wherever a timing stage must also carry backpressure (e.g. AMM cmd/wdata toward the controller).
//
// PARAMETERS
//  WIDTH   32  payload bits per beat (>=1)
//  DEPTH   1   number of skid-buffer stages (0..8); 0 = combinational pass-through
//
// PORTS
//  clk        in   1             clock
//  reset_n    in   1             reset, asynchronous, active-low
//  flush      in   1             synchronous clear of all buffered beats
//  in_valid   in   1             upstream beat valid
//  in_ready   out  1             upstream may transfer (registered when DEPTH>0)
//  in_data    in   WIDTH         upstream payload
//  out_valid  out  1             downstream beat valid (registered when DEPTH>0)
//  out_ready  in   1             downstream accepts
//  out_data   out  WIDTH         downstream payload (registered when DEPTH>0)
//  occupancy  out  $clog2(2*DEPTH+1)  beats currently held (see CONFIGURATION)
//
// BEHAVIOUR
//  - Transfer on either side = valid & ready in the same cycle. Beats are never dropped,
//    duplicated or reordered, except by flush.
//  - Reset (async assert, sync-to-clk deassert by the caller) values:
//    - every main_valid and skid_valid = 0
//    - all data regs = 0
//    - in_ready = 1, out_valid = 0, out_data = 0, occupancy = 0
//  - Per stage: main reg (drives the next stage) plus skid reg.
//    - ready_to_prev = registered ~skid_valid.
//    - Accept while main is empty, or while main is draining this cycle: load main.
//    - Accept while main is full and stalled: load skid.
//    - Main drains with skid full: main <= skid, skid_valid <= 0.
//  - Stage states: EMPTY (main=0, skid=0), HALF (1,0), FULL (1,1).
//    - EMPTY -> HALF on accept.
//    - HALF -> HALF on accept+drain; HALF -> EMPTY on drain only; HALF -> FULL on accept with no drain.
//    - FULL -> HALF on drain. No accept is possible in FULL because ready=0.
//  - Latency: DEPTH cycles from in transfer to out_valid when unstalled. Throughput 1 beat/cycle sustained.
//  - Stall: out_ready=0 for >= 2*DEPTH beats fills the chain. in_ready falls exactly when the first stage's skid fills.
//  - Empty chain: out_valid=0 and out_data holds its last value. out_data is don't-care for checking while out_valid=0.
//  - flush=1 (sync): the next cycle has all valids = 0, in_ready = 1, occupancy = 0.
//    - A beat transferred in on the flush cycle is discarded.
//    - An output transfer on the flush cycle still counts as delivered.
//  - Simultaneous in and out transfer on a full-throughput chain: occupancy unchanged.
//  - DEPTH=0: in_ready=out_ready, out_valid=in_valid, out_data=in_data. flush is ignored; occupancy=0.
//  - Data regs have no reset requirement beyond 0. AUTO_SHIFT_REGISTER_RECOGNITION stays OFF and the module is dont_merge.
//
// CONFIGURATION
//  Macro ALTERA_EMIF_HS_PIPE_OCCUPANCY_EN:
//  - Defined: occupancy is a registered count of valid main+skid entries across all stages, range 0..2*DEPTH.
//    It updates on the cycle after each transfer: +1 per in transfer, -1 per out transfer, reset to 0 by flush.
//  - Undefined: occupancy is tied to 0 and no counter logic is built. The port is always present.
//
// TESTING
//  - Reset: assert reset_n=0 mid-stream with 3 beats held, DEPTH=2 -> same cycle: out_valid=0, in_ready=1, occupancy=0.
//  - Streaming: DEPTH=3, WIDTH=32, push 0x1..0x64 with out_ready=1 -> out_data 0x1 appears 3 cycles later.
//    Then 100 consecutive beats in order with no bubbles.
//  - Backpressure: DEPTH=2, out_ready=0, in_valid=1 -> exactly 4 beats accepted; in_ready=0 from cycle 4 on; occupancy=4 (macro on).
//    Release out_ready -> 4 beats out in order, in_ready back to 1 one cycle later.
//  - Random valid/ready: 50% in_valid and out_ready toggling for 10k beats, DEPTH=1..4 -> scoreboard exact match, no X.
//    Also check: in_ready low never when first-stage skid is empty.
//  - Flush: 3 beats held, flush=1 while in_valid=1 with data 0xAA -> next cycle out_valid=0, occupancy=0. 0xAA is never output.
//  - DEPTH=0: random stimulus -> out equals in combinationally, occupancy=0. With the macro undefined, occupancy=0 in all tests.

Source files
------------

// File: rtl/altera_emif_arch_nf_hs_pipe.sv
// Valid/ready pipeline of DEPTH skid-buffer stages, each with a registered ready to upstream.
// Optional occupancy counter built only when ALTERA_EMIF_HS_PIPE_OCCUPANCY_EN is defined.
(* altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF; -name DONT_MERGE_REGISTER ON" *)
module altera_emif_arch_nf_hs_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1,
    localparam int unsigned OccW = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [OccW-1:0]  occupancy_o
);

    if (DEPTH == 0) begin : g_wire
        assign in_ready_o  = out_ready_i;
        assign out_valid_o = in_valid_i;
        assign out_data_o  = in_data_i;
        assign occupancy_o = '0;

        logic unused_wire;
        assign unused_wire = ^{clk, reset_n, flush_i};
    end else begin : g_pipe
        logic [DEPTH-1:0] main_valid_q, main_valid_d;
        logic [DEPTH-1:0] skid_valid_q, skid_valid_d;
        logic [WIDTH-1:0] main_data_q [DEPTH];
        logic [WIDTH-1:0] main_data_d [DEPTH];
        logic [WIDTH-1:0] skid_data_q [DEPTH];
        logic [WIDTH-1:0] skid_data_d [DEPTH];

        // Boundary i sits in front of stage i; boundary DEPTH is the output port.
        logic [DEPTH:0]   chain_valid;
        logic [DEPTH:0]   chain_ready;
        logic [WIDTH-1:0] chain_data [DEPTH+1];
        logic [DEPTH-1:0] accept;
        logic [DEPTH-1:0] drain;

        always_comb begin
            chain_valid   = {main_valid_q, in_valid_i};
            chain_ready   = {out_ready_i, ~skid_valid_q};
            chain_data[0] = in_data_i;
            for (int i = 0; i < int'(DEPTH); i++) begin
                chain_data[i+1] = main_data_q[i];
            end
        end

        always_comb begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
            main_data_d  = main_data_q;
            skid_data_d  = skid_data_q;
            accept       = '0;
            drain        = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                accept[i] = chain_valid[i] & chain_ready[i];
                drain[i]  = main_valid_q[i] & chain_ready[i+1];
                if (drain[i]) begin
                    if (skid_valid_q[i]) begin
                        // Ready was low, so no accept can coincide with a skid refill.
                        main_data_d[i]  = skid_data_q[i];
                        skid_valid_d[i] = 1'b0;
                    end else if (accept[i]) begin
                        main_data_d[i] = chain_data[i];
                    end else begin
                        main_valid_d[i] = 1'b0;
                    end
                end else if (accept[i]) begin
                    if (main_valid_q[i]) begin
                        skid_valid_d[i] = 1'b1;
                        skid_data_d[i]  = chain_data[i];
                    end else begin
                        main_valid_d[i] = 1'b1;
                        main_data_d[i]  = chain_data[i];
                    end
                end
            end
            if (flush_i) begin
                main_valid_d = '0;
                skid_valid_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                main_valid_q <= '0;
                skid_valid_q <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    main_data_q[i] <= '0;
                    skid_data_q[i] <= '0;
                end
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                main_data_q  <= main_data_d;
                skid_data_q  <= skid_data_d;
            end
        end

        assign in_ready_o  = chain_ready[0];
        assign out_valid_o = chain_valid[DEPTH];
        assign out_data_o  = chain_data[DEPTH];

`ifdef ALTERA_EMIF_HS_PIPE_OCCUPANCY_EN
        logic [OccW-1:0] occ_q, occ_d;
        logic            in_xfer, out_xfer;

        always_comb begin
            in_xfer  = in_valid_i & chain_ready[0];
            out_xfer = chain_valid[DEPTH] & out_ready_i;
            if (flush_i) begin
                occ_d = '0;
            end else begin
                occ_d = occ_q + OccW'(in_xfer) - OccW'(out_xfer);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy_o = occ_q;
`else
        assign occupancy_o = '0;
`endif
    end

endmodule
